// File: rtl/bcd_disp_pkg.sv
// Shared seven-segment constants for the two-digit BCD display scanner.
// Segment order is {g,f,e,d,c,b,a}; all patterns are active-low.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;
  localparam logic [1:0] AN_OFF  = 2'b11;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Non-BCD codes 10..15 show 'E' so a corrupted upstream sum is visible.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segOut
);

  always_comb begin
    segOut = SEG_E;
    if (digit < 4'd10) segOut = SEG_DIGIT[digit];
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed seven-segment driver with frame-aligned digit commit.
// Optional leading-zero blanking of the tens digit: define BCD_BLANK_ZERO_EN.
module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_tens,
  input  logic [3:0] in_ones,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] divCnt;
  logic             digitSel;
  logic             pendVld;
  logic [3:0]       pendTens, pendOnes;
  logic [3:0]       dispTens, dispOnes;
  logic             slotEnd, frameEnd, accept;
  logic [3:0]       curDigit;
  logic [6:0]       decSeg, segNext;

  assign in_ready = ~pendVld;
  assign slotEnd  = (divCnt == CNT_LAST);
  assign frameEnd = slotEnd && digitSel;
  assign accept   = in_valid && ~pendVld;

  // Stage 0: free-running scan timebase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCnt   <= '0;
      digitSel <= 1'b0;
    end else if (slotEnd) begin
      divCnt   <= '0;
      digitSel <= ~digitSel;
    end else begin
      divCnt   <= divCnt + 1'b1;
    end
  end

  // Pending pair is only committed at the end of the tens slot so a frame
  // never shows digits from two different sums. Accept and commit are
  // mutually exclusive because accept requires an empty pending register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pendVld  <= 1'b0;
      pendTens <= '0;
      pendOnes <= '0;
      dispTens <= '0;
      dispOnes <= '0;
    end else if (frameEnd && pendVld) begin
      dispTens <= pendTens;
      dispOnes <= pendOnes;
      pendVld  <= 1'b0;
    end else if (accept) begin
      pendTens <= in_tens;
      pendOnes <= in_ones;
      pendVld  <= 1'b1;
    end
  end

  assign curDigit = digitSel ? dispTens : dispOnes;

  bcd_to_seg uDecode (
    .digit  (curDigit),
    .segOut (decSeg)
  );

  always_comb begin
    segNext = decSeg;
`ifdef BCD_BLANK_ZERO_EN
    if (digitSel && (dispTens == 4'd0)) segNext = SEG_BLANK;
`endif
  end

  // Stage 1: registered display outputs, one cycle behind digitSel/disp
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
    end else begin
      seg <= segNext;
      an  <= digitSel ? AN_TENS : AN_ONES;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed self-checking bench for bcd_display_scan with SCAN_DIV=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bcd_display_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_tens, in_ones;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] seg;
  logic [1:0] an;

  int errors = 0;
  int checks = 0;
  int cyc = 0;  // rising edges since the last reset release

`ifdef BCD_BLANK_ZERO_EN
  localparam logic [6:0] ZERO_TENS = 7'b1111111;
`else
  localparam logic [6:0] ZERO_TENS = 7'b1000000;
`endif

  bcd_display_scan #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_tens  (in_tens),
    .in_ones  (in_ones),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Frame is 8 cycles; phase p means the sample after rising edge cyc%8==p.
  task automatic waitPhase(input int p);
    for (int i = 0; i < 8 && (cyc % 8) != p; i++) step();
  endtask

  task automatic expectOut(input string name, input logic [1:0] anExp,
                           input logic [6:0] segExp);
    checks++;
    if (an !== anExp || seg !== segExp) begin
      errors++;
      $display("FAIL %s: an=%b seg=%b, required an=%b seg=%b", name, an, seg, anExp, segExp);
    end
  endtask

  task automatic expectReady(input string name, input logic exp);
    checks++;
    if (in_ready !== exp) begin
      errors++;
      $display("FAIL %s: in_ready=%b, required %b", name, in_ready, exp);
    end
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic sendPair(input logic [3:0] t, input logic [3:0] o);
    in_tens  = t;
    in_ones  = o;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] anSeq [0:9];
    logic [6:0] segExp;
    anSeq = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    reset = 1'b1;
    in_valid = 1'b0;
    in_tens = '0;
    in_ones = '0;
    repeat (3) @(negedge clk);
    releaseReset();
    expectReady("reset_ready", 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k == 0)                segExp = 7'b1111111;
      else if (anSeq[k] == 2'b01) segExp = ZERO_TENS;
      else                        segExp = 7'b1000000;
      expectOut($sformatf("reset_scan%0d", k), anSeq[k], segExp);
      if (k < 9) step();
    end
  endtask

  task automatic test_accept();
    waitPhase(1);
    sendPair(4'd1, 4'd9);
    expectReady("accept_ready_low", 1'b0);
    waitPhase(7);
    expectReady("accept_ready_held", 1'b0);
    expectOut("accept_old_tens", 2'b01, ZERO_TENS);
    step();
    expectReady("accept_ready_back", 1'b1);
    expectOut("accept_old_tens_last", 2'b01, ZERO_TENS);
    step();
    expectOut("accept_new_ones", 2'b10, 7'b0010000);
    waitPhase(5);
    expectOut("accept_new_tens", 2'b01, 7'b1111001);
  endtask

  task automatic test_back_to_back();
    waitPhase(1);
    sendPair(4'd0, 4'd5);
    in_tens  = 4'd1;
    in_ones  = 4'd3;
    in_valid = 1'b1;
    expectReady("b2b_busy", 1'b0);
    waitPhase(0);
    expectReady("b2b_freed", 1'b1);
    step();
    in_valid = 1'b0;
    expectReady("b2b_second_taken", 1'b0);
    expectOut("b2b_first_ones", 2'b10, 7'b0010010);
    waitPhase(5);
    expectOut("b2b_first_tens", 2'b01, ZERO_TENS);
    waitPhase(1);
    expectOut("b2b_second_ones", 2'b10, 7'b0110000);
    waitPhase(5);
    expectOut("b2b_second_tens", 2'b01, 7'b1111001);
  endtask

  task automatic test_error_digit();
    waitPhase(1);
    sendPair(4'd2, 4'hC);
    waitPhase(1);
    expectOut("err_ones_E", 2'b10, 7'b0000110);
    waitPhase(5);
    expectOut("err_tens_2", 2'b01, 7'b0100100);
  endtask

  task automatic test_zero_tens();
    waitPhase(1);
    sendPair(4'd0, 4'd7);
    waitPhase(1);
    expectOut("zero_ones_7", 2'b10, 7'b1111000);
    waitPhase(5);
    expectOut("zero_tens", 2'b01, ZERO_TENS);
  endtask

  task automatic test_reset_pending();
    waitPhase(1);
    sendPair(4'd8, 4'd8);
    waitPhase(5);
    expectReady("rstp_pending", 1'b0);
    #1 reset = 1'b1;
    #1;
    expectOut("rstp_async_blank", 2'b11, 7'b1111111);
    expectReady("rstp_async_ready", 1'b1);
    releaseReset();
    step();
    expectOut("rstp_ones_zero", 2'b10, 7'b1000000);
    waitPhase(5);
    expectOut("rstp_tens_zero", 2'b01, ZERO_TENS);
    step();
    step();
    step();
    step();
    expectOut("rstp_pend_discarded", 2'b10, 7'b1000000);
  endtask

  initial begin
    test_reset();
    test_accept();
    test_back_to_back();
    test_error_digit();
    test_zero_tens();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
